bg_removal_sequencer: RTL and testbench
=======================================

BG_REMOVAL_SEQUENCER -- requirements
Module: bg_removal_sequencer

Interface
REQ-001 SHALL have parameter NUM_PE, default 2, number of pe instances sequenced.
REQ-002 SHALL have parameter NUM_PIXELS, default 4, pixels per pe.
REQ-003 SHALL have parameter SUM_W, default 16, width of each per-pe channel sum.
REQ-004 SHALL have parameter TIMEOUT, default 1024, max cycles in a wait state.
REQ-005 SHALL have port Clk, in, 1, single clock; all state changes on rising edge.
REQ-006 SHALL have port Reset, in, 1, asynchronous active-low reset.
REQ-007 SHALL have port Go, in, 1, host request to process one frame.
REQ-008 SHALL have port Host_Ack, in, 1, host acknowledge of Done/Error.
REQ-009 SHALL have ports Threshold_in and Bg_r_in, Bg_g_in, Bg_b_in, in, 8 each, frame configuration.
REQ-010 SHALL have ports Qsd_in and Qbgd_in, in, NUM_PE each, per-pe sum-done and bg-done flags.
REQ-011 SHALL have ports Red_sum_in, Green_sum_in and Blue_sum_in, in, NUM_PE*SUM_W each, per-pe sums; pe k at bits [k*SUM_W +: SUM_W].
REQ-012 SHALL have ports Start_Sum and Start_BgRemoval, out, 1 each, broadcast start pulses to all pes.
REQ-013 SHALL have port Pe_Ack, out, 1, broadcast pe acknowledge.
REQ-014 SHALL have ports Red_exp, Green_exp and Blue_exp, out, 8 each, expected background colour.
REQ-015 SHALL have ports Threshold, Desired_bg_r, Desired_bg_g and Desired_bg_b, out, 8 each, latched configuration.
REQ-016 SHALL have ports Busy, Done and Error, out, 1 each, status.

Function
REQ-017 SHALL implement states IDLE, SUM_START, SUM_WAIT, ACCUM, DIVIDE, BG_START, BG_WAIT, DONE and ERROR.
REQ-018 In IDLE, Go=1 SHALL latch Threshold_in and Bg_*_in into the config outputs and enter SUM_START; Go in any other state SHALL be ignored.
REQ-019 SUM_START SHALL drive Start_Sum=1 for exactly one cycle, clear the accumulators and timeout counter, then enter SUM_WAIT.
REQ-020 SUM_WAIT SHALL enter ACCUM when all Qsd_in bits are 1, or ERROR when the timeout counter reaches TIMEOUT-1.
REQ-021 ACCUM SHALL add pe k's three sums into three accumulators of width SUM_W+clog2(NUM_PE), with k counting 0..NUM_PE-1, one pe per cycle (NUM_PE cycles), then enter DIVIDE.
REQ-022 DIVIDE SHALL, in one cycle, set each *_exp to accumulator >> log2(NUM_PE*NUM_PIXELS), saturated to 255, then enter BG_START.
REQ-023 NUM_PE*NUM_PIXELS SHALL be a power of two; elaboration SHALL fail otherwise.
REQ-024 BG_START SHALL drive Start_BgRemoval=1 for exactly one cycle with *_exp and config outputs stable, reset the timeout counter, then enter BG_WAIT.
REQ-025 BG_WAIT SHALL enter DONE when all Qbgd_in bits are 1, or ERROR on timeout as in REQ-020.
REQ-026 Pe_Ack SHALL be 1 in SUM_WAIT, ACCUM, DIVIDE, BG_WAIT and DONE, and 0 otherwise.
REQ-027 DONE SHALL hold Done=1 and ERROR SHALL hold Error=1 until Host_Ack=1, then enter IDLE.
REQ-028 Busy SHALL be 1 in every state except IDLE.
REQ-029 *_exp and the config outputs SHALL hold their values until the next Go is accepted.
REQ-030 Host_Ack in IDLE SHALL have no effect; Go and Host_Ack together in DONE/ERROR SHALL return to IDLE, and Go SHALL NOT be accepted that cycle.
REQ-031 Latency with pes done immediately SHALL be: Go sampled at edge 0; Start_Sum at cycle 1; Start_BgRemoval at cycle 3+NUM_PE+1; Done at cycle 3+NUM_PE+3.

Reset
REQ-032 Reset=0 SHALL asynchronously force IDLE and set every output, counter and accumulator to 0, including mid-operation.
REQ-033 After Reset returns to 1, the first Go SHALL be accepted on the next rising edge.

Structure
REQ-034 Package bgr_pkg SHALL hold the state enum, the pixel width constant (8) and the saturation constant (255).
REQ-035 A sub-module channel_accumulator (clear, add-enable, operand, shift, saturated 8-bit result) SHALL be instantiated three times, once per channel.

Verification
REQ-036 NUM_PE=2, both pes report sums 387/399/594, Qsd then Qbgd asserted -> Red_exp=96, Green_exp=99, Blue_exp=148; Done=1 until Host_Ack.
REQ-037 Go with Threshold_in=60, Bg=106/168/79 -> the same values appear on Threshold/Desired_bg_* and hold through Done.
REQ-038 Sums 0xFFFF from both pes -> all *_exp=255 (saturation).
REQ-039 Qsd_in held at 2'b01, TIMEOUT=64 -> Error=1 after 64 cycles in SUM_WAIT; no Start_BgRemoval pulse.
REQ-040 Reset=0 asserted during BG_WAIT -> all outputs 0 immediately and state IDLE; a new Go runs to Done normally.
REQ-041 Go pulsed during SUM_WAIT -> ignored; exactly one Start_Sum pulse per frame.

Source files
------------

// File: rtl/bgr_pkg.sv
// Shared types and constants for the background-removal sequencer.
package bgr_pkg;

  localparam int unsigned PIX_W = 8;
  localparam logic [PIX_W-1:0] SAT_MAX = 8'd255;

  typedef enum logic [3:0] {
    IDLE,
    SUM_START,
    SUM_WAIT,
    ACCUM,
    DIVIDE,
    BG_START,
    BG_WAIT,
    DONE,
    ERROR
  } state_t;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/bg_removal_sequencer_if.sv
// Host / processing-element bus of the background-removal sequencer.
interface bg_removal_sequencer_if #(
  parameter int unsigned NUM_PE = 2,
  parameter int unsigned SUM_W  = 16
);
  import bgr_pkg::*;

  logic                    Go;
  logic                    Host_Ack;
  logic [PIX_W-1:0]        Threshold_in;
  logic [PIX_W-1:0]        Bg_r_in;
  logic [PIX_W-1:0]        Bg_g_in;
  logic [PIX_W-1:0]        Bg_b_in;
  logic [NUM_PE-1:0]       Qsd_in;
  logic [NUM_PE-1:0]       Qbgd_in;
  logic [NUM_PE*SUM_W-1:0] Red_sum_in;
  logic [NUM_PE*SUM_W-1:0] Green_sum_in;
  logic [NUM_PE*SUM_W-1:0] Blue_sum_in;

  logic                    Start_Sum;
  logic                    Start_BgRemoval;
  logic                    Pe_Ack;
  logic [PIX_W-1:0]        Red_exp;
  logic [PIX_W-1:0]        Green_exp;
  logic [PIX_W-1:0]        Blue_exp;
  logic [PIX_W-1:0]        Threshold;
  logic [PIX_W-1:0]        Desired_bg_r;
  logic [PIX_W-1:0]        Desired_bg_g;
  logic [PIX_W-1:0]        Desired_bg_b;
  logic                    Busy;
  logic                    Done;
  logic                    Error;

  // Host and pe array side.
  modport master (
    output Go, Host_Ack, Threshold_in, Bg_r_in, Bg_g_in, Bg_b_in,
           Qsd_in, Qbgd_in, Red_sum_in, Green_sum_in, Blue_sum_in,
    input  Start_Sum, Start_BgRemoval, Pe_Ack, Red_exp, Green_exp, Blue_exp,
           Threshold, Desired_bg_r, Desired_bg_g, Desired_bg_b, Busy, Done, Error
  );

  // Sequencer side.
  modport slave (
    input  Go, Host_Ack, Threshold_in, Bg_r_in, Bg_g_in, Bg_b_in,
           Qsd_in, Qbgd_in, Red_sum_in, Green_sum_in, Blue_sum_in,
    output Start_Sum, Start_BgRemoval, Pe_Ack, Red_exp, Green_exp, Blue_exp,
           Threshold, Desired_bg_r, Desired_bg_g, Desired_bg_b, Busy, Done, Error
  );

endinterface

// File: rtl/channel_accumulator.sv
// One colour channel: sums per-pe totals, then divides by a power of two
// and saturates to a pixel value.
module channel_accumulator
  import bgr_pkg::*;
#(
  parameter int unsigned OP_W  = 16,
  parameter int unsigned ACC_W = 17,
  parameter int unsigned SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             add_en,
  input  logic [OP_W-1:0]  operand,
  output logic [PIX_W-1:0] res_c
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] shifted_c;

  // Clear has priority over accumulation.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + ACC_W'(operand);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  // Mean value clipped to the pixel range.
  always_comb begin
    shifted_c = acc_q >> SHIFT;
    if (shifted_c > ACC_W'(SAT_MAX)) res_c = SAT_MAX;
    else                             res_c = PIX_W'(shifted_c);
  end

endmodule

// File: rtl/bg_removal_sequencer.sv
// Frame sequencer: runs the pe sum pass, derives the expected background
// colour, then runs the background-removal pass and reports to the host.
module bg_removal_sequencer
  import bgr_pkg::*;
#(
  parameter int unsigned NUM_PE     = 2,
  parameter int unsigned NUM_PIXELS = 4,
  parameter int unsigned SUM_W      = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic                   Clk,
  input logic                   Reset,
  bg_removal_sequencer_if.slave bus
);

  localparam int unsigned TOTAL = NUM_PE * NUM_PIXELS;
  localparam int unsigned SHIFT = $clog2(TOTAL);
  localparam int unsigned ACC_W = SUM_W + $clog2(NUM_PE);
  localparam int unsigned K_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // The mean is a plain shift, so the pixel count must be a power of two.
  if (!is_pow2(TOTAL)) begin : g_size_check
    $error("NUM_PE*NUM_PIXELS must be a power of two");
  end

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [PIX_W-1:0]  thr_q, thr_d, bgr_q, bgr_d, bgg_q, bgg_d, bgb_q, bgb_d;
  logic [PIX_W-1:0]  rexp_q, rexp_d, gexp_q, gexp_d, bexp_q, bexp_d;
  logic              start_sum_q, start_sum_d, start_bg_q, start_bg_d;
  logic              pe_ack_q, pe_ack_d, busy_q, busy_d;
  logic              done_q, done_d, error_q, error_d;
  logic              acc_clear_c, acc_add_c;
  logic [PIX_W-1:0]  rres_c, gres_c, bres_c;
  logic [SUM_W-1:0]  red_c [NUM_PE];
  logic [SUM_W-1:0]  grn_c [NUM_PE];
  logic [SUM_W-1:0]  blu_c [NUM_PE];

  // Split the flat sum buses into per-pe operands.
  for (genvar i = 0; i < NUM_PE; i++) begin : g_unpack
    assign red_c[i] = bus.Red_sum_in[i*SUM_W +: SUM_W];
    assign grn_c[i] = bus.Green_sum_in[i*SUM_W +: SUM_W];
    assign blu_c[i] = bus.Blue_sum_in[i*SUM_W +: SUM_W];
  end

  channel_accumulator #(.OP_W(SUM_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_acc_r (
    .clk(Clk), .rst_n(Reset), .clear(acc_clear_c), .add_en(acc_add_c),
    .operand(red_c[k_q]), .res_c(rres_c)
  );
  channel_accumulator #(.OP_W(SUM_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_acc_g (
    .clk(Clk), .rst_n(Reset), .clear(acc_clear_c), .add_en(acc_add_c),
    .operand(grn_c[k_q]), .res_c(gres_c)
  );
  channel_accumulator #(.OP_W(SUM_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_acc_b (
    .clk(Clk), .rst_n(Reset), .clear(acc_clear_c), .add_en(acc_add_c),
    .operand(blu_c[k_q]), .res_c(bres_c)
  );

  // Next state, counters and datapath; status outputs decode the next state.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    tmo_d       = tmo_q;
    thr_d       = thr_q;
    bgr_d       = bgr_q;
    bgg_d       = bgg_q;
    bgb_d       = bgb_q;
    rexp_d      = rexp_q;
    gexp_d      = gexp_q;
    bexp_d      = bexp_q;
    acc_clear_c = 1'b0;
    acc_add_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Go) begin
          thr_d   = bus.Threshold_in;
          bgr_d   = bus.Bg_r_in;
          bgg_d   = bus.Bg_g_in;
          bgb_d   = bus.Bg_b_in;
          state_d = SUM_START;
        end
      end
      SUM_START: begin
        acc_clear_c = 1'b1;
        tmo_d       = '0;
        k_d         = '0;
        state_d     = SUM_WAIT;
      end
      SUM_WAIT: begin
        if (&bus.Qsd_in)                    state_d = ACCUM;
        else if (tmo_q == TO_W'(TIMEOUT-1)) state_d = ERROR;
        else                                tmo_d   = tmo_q + TO_W'(1);
      end
      ACCUM: begin
        acc_add_c = 1'b1;
        if (k_q == K_W'(NUM_PE-1)) state_d = DIVIDE;
        else                       k_d     = k_q + K_W'(1);
      end
      DIVIDE: begin
        rexp_d  = rres_c;
        gexp_d  = gres_c;
        bexp_d  = bres_c;
        state_d = BG_START;
      end
      BG_START: begin
        tmo_d   = '0;
        state_d = BG_WAIT;
      end
      BG_WAIT: begin
        if (&bus.Qbgd_in)                   state_d = DONE;
        else if (tmo_q == TO_W'(TIMEOUT-1)) state_d = ERROR;
        else                                tmo_d   = tmo_q + TO_W'(1);
      end
      DONE, ERROR: begin
        if (bus.Host_Ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_sum_d = (state_d == SUM_START);
    start_bg_d  = (state_d == BG_START);
    pe_ack_d    = (state_d == SUM_WAIT) || (state_d == ACCUM) || (state_d == DIVIDE) ||
                  (state_d == BG_WAIT)  || (state_d == DONE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      tmo_q       <= '0;
      thr_q       <= '0;
      bgr_q       <= '0;
      bgg_q       <= '0;
      bgb_q       <= '0;
      rexp_q      <= '0;
      gexp_q      <= '0;
      bexp_q      <= '0;
      start_sum_q <= 1'b0;
      start_bg_q  <= 1'b0;
      pe_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      tmo_q       <= tmo_d;
      thr_q       <= thr_d;
      bgr_q       <= bgr_d;
      bgg_q       <= bgg_d;
      bgb_q       <= bgb_d;
      rexp_q      <= rexp_d;
      gexp_q      <= gexp_d;
      bexp_q      <= bexp_d;
      start_sum_q <= start_sum_d;
      start_bg_q  <= start_bg_d;
      pe_ack_q    <= pe_ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.Start_Sum       = start_sum_q;
  assign bus.Start_BgRemoval = start_bg_q;
  assign bus.Pe_Ack          = pe_ack_q;
  assign bus.Red_exp         = rexp_q;
  assign bus.Green_exp       = gexp_q;
  assign bus.Blue_exp        = bexp_q;
  assign bus.Threshold       = thr_q;
  assign bus.Desired_bg_r    = bgr_q;
  assign bus.Desired_bg_g    = bgg_q;
  assign bus.Desired_bg_b    = bgb_q;
  assign bus.Busy            = busy_q;
  assign bus.Done            = done_q;
  assign bus.Error           = error_q;

endmodule

// File: tb/tb_bg_removal_sequencer.sv
// Directed and randomized frames against a frame-level reference model.
module tb_bg_removal_sequencer;

  localparam int unsigned NUM_PE     = 2;
  localparam int unsigned NUM_PIXELS = 4;
  localparam int unsigned SUM_W      = 16;
  localparam int unsigned TIMEOUT    = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bg_removal_sequencer_if #(.NUM_PE(NUM_PE), .SUM_W(SUM_W)) bus ();

  bg_removal_sequencer #(
    .NUM_PE(NUM_PE), .NUM_PIXELS(NUM_PIXELS), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(clk), .Reset(rst_n), .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mean of all pixels of one channel, clipped to 255.
  function automatic logic [7:0] mean_of(input logic [31:0] s);
    int unsigned t;
    t = (int'(s[15:0]) + int'(s[31:16])) / (NUM_PE * NUM_PIXELS);
    return (t > 255) ? 8'd255 : 8'(t);
  endfunction

  function automatic logic [63:0] all_out();
    return {2'b00, bus.Start_Sum, bus.Start_BgRemoval, bus.Pe_Ack, bus.Busy, bus.Done,
            bus.Error, bus.Red_exp, bus.Green_exp, bus.Blue_exp, bus.Threshold,
            bus.Desired_bg_r, bus.Desired_bg_g, bus.Desired_bg_b};
  endfunction

  task automatic set_frame(input logic [7:0] thr, br, bgn, bb, input logic [31:0] rs, gs, bs);
    bus.Threshold_in = thr;
    bus.Bg_r_in      = br;
    bus.Bg_g_in      = bgn;
    bus.Bg_b_in      = bb;
    bus.Red_sum_in   = rs;
    bus.Green_sum_in = gs;
    bus.Blue_sum_in  = bs;
    bus.Qsd_in       = '0;
    bus.Qbgd_in      = '0;
  endtask

  task automatic frame(input string nm, input logic [7:0] thr, br, bgn, bb,
                       input logic [31:0] rs, gs, bs, input int d_sum, input int d_bg,
                       input bit go_glitch, input bit ack_with_go);
    int c, sb, dn, nss, nbg;
    logic [23:0] exp_rgb;
    exp_rgb = {mean_of(rs), mean_of(gs), mean_of(bs)};
    set_frame(thr, br, bgn, bb, rs, gs, bs);
    bus.Go = 1'b1;
    step();
    bus.Go = 1'b0;
    c = 0; sb = -1; dn = -1; nbg = 0;
    nss = int'(bus.Start_Sum);
    chk({nm, ":start_sum"}, 64'(bus.Start_Sum), 64'd1);
    chk({nm, ":cfg_latch"}, 64'({bus.Threshold, bus.Desired_bg_r, bus.Desired_bg_g,
        bus.Desired_bg_b}), 64'({thr, br, bgn, bb}));
    while (dn < 0 && c < 400) begin
      bus.Go = go_glitch && (c == 2);
      if (c == 1 + d_sum) bus.Qsd_in = '1;
      if (sb >= 0 && c == sb + 1 + d_bg) bus.Qbgd_in = '1;
      step();
      c++;
      if (c == 1) chk({nm, ":sumwait_ack"}, 64'({bus.Pe_Ack, bus.Start_Sum}), 64'b10);
      nss += int'(bus.Start_Sum);
      nbg += int'(bus.Start_BgRemoval);
      if (bus.Start_BgRemoval && sb < 0) begin
        sb = c;
        chk({nm, ":exp_at_bgstart"}, 64'({bus.Red_exp, bus.Green_exp, bus.Blue_exp}),
            64'(exp_rgb));
      end
      if (bus.Done) dn = c;
    end
    bus.Go = 1'b0;
    chk({nm, ":lat_bgstart"}, 64'(sb), 64'(NUM_PE + 3 + d_sum));
    chk({nm, ":lat_done"}, 64'(dn), 64'(sb + 2 + d_bg));
    chk({nm, ":n_start_sum"}, 64'(nss), 64'd1);
    chk({nm, ":n_start_bg"}, 64'(nbg), 64'd1);
    chk({nm, ":exp"}, 64'({bus.Red_exp, bus.Green_exp, bus.Blue_exp}), 64'(exp_rgb));
    chk({nm, ":cfg_hold"}, 64'({bus.Threshold, bus.Desired_bg_r, bus.Desired_bg_g,
        bus.Desired_bg_b}), 64'({thr, br, bgn, bb}));
    chk({nm, ":done_status"}, 64'({bus.Done, bus.Busy, bus.Pe_Ack, bus.Error}), 64'b1110);
    repeat ($urandom_range(1, 4)) step();
    chk({nm, ":done_held"}, 64'({bus.Done, bus.Busy}), 64'b11);
    bus.Host_Ack = 1'b1;
    bus.Go       = ack_with_go;
    step();
    bus.Host_Ack = 1'b0;
    bus.Go       = 1'b0;
    chk({nm, ":ack_idle"}, 64'({bus.Done, bus.Busy, bus.Pe_Ack}), 64'b000);
    step();
    chk({nm, ":no_restart"}, 64'({bus.Start_Sum, bus.Busy}), 64'b00);
    chk({nm, ":exp_idle_hold"}, 64'({bus.Red_exp, bus.Green_exp, bus.Blue_exp}),
        64'(exp_rgb));
    bus.Qsd_in  = '0;
    bus.Qbgd_in = '0;
  endtask

  initial begin
    int c, er, nbg, d_sum;
    logic [31:0] rs, gs, bs;

    bus.Go = 1'b0;
    bus.Host_Ack = 1'b0;
    set_frame(8'd0, 8'd0, 8'd0, 8'd0, 32'd0, 32'd0, 32'd0);

    // Reset state, then Host_Ack in IDLE has no effect.
    step();
    step();
    chk("reset_outputs", all_out(), 64'd0);
    rst_n = 1'b1;
    bus.Host_Ack = 1'b1;
    step();
    bus.Host_Ack = 1'b0;
    chk("ack_in_idle", all_out(), 64'd0);

    // Nominal frame with immediate pes, spec latency.
    frame("nominal", 8'd60, 8'd106, 8'd168, 8'd79, {16'd387, 16'd387},
          {16'd399, 16'd399}, {16'd594, 16'd594}, 0, 0, 1'b0, 1'b0);
    chk("nominal_red", 64'(bus.Red_exp), 64'd96);
    chk("nominal_green", 64'(bus.Green_exp), 64'd99);
    chk("nominal_blue", 64'(bus.Blue_exp), 64'd148);

    // Saturation.
    frame("saturate", 8'd7, 8'd1, 8'd2, 8'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 1, 2, 1'b0, 1'b1);

    // Go pulsed during SUM_WAIT is ignored.
    frame("go_glitch", 8'd33, 8'd44, 8'd55, 8'd66, {16'd100, 16'd900},
          {16'd2040, 16'd0}, {16'd8, 16'd7}, 3, 1, 1'b1, 1'b0);

    // Timeout in SUM_WAIT with only one pe done.
    set_frame(8'd9, 8'd9, 8'd9, 8'd9, 32'd0, 32'd0, 32'd0);
    bus.Qsd_in = 2'b01;
    bus.Go = 1'b1;
    step();
    bus.Go = 1'b0;
    c = 0; er = -1; nbg = 0;
    while (er < 0 && c < 200) begin
      step();
      c++;
      nbg += int'(bus.Start_BgRemoval);
      if (bus.Error) er = c;
    end
    chk("timeout_latency", 64'(er), 64'(1 + TIMEOUT));
    chk("timeout_no_bg", 64'(nbg), 64'd0);
    chk("timeout_status", 64'({bus.Done, bus.Busy, bus.Pe_Ack}), 64'b010);
    repeat (3) step();
    chk("error_held", 64'(bus.Error), 64'd1);
    bus.Host_Ack = 1'b1;
    step();
    bus.Host_Ack = 1'b0;
    bus.Qsd_in = '0;
    chk("error_ack", 64'({bus.Error, bus.Busy}), 64'b00);

    // Asynchronous reset during BG_WAIT, then a clean frame.
    set_frame(8'd1, 8'd2, 8'd3, 8'd4, {16'd80, 16'd80}, {16'd80, 16'd80}, {16'd80, 16'd80});
    bus.Go = 1'b1;
    step();
    bus.Go = 1'b0;
    bus.Qsd_in = '1;
    c = 0;
    while (!bus.Start_BgRemoval && c < 50) begin
      step();
      c++;
    end
    chk("rst_reach_bgstart", 64'(bus.Start_BgRemoval), 64'd1);
    step();
    step();
    chk("rst_in_bgwait", 64'({bus.Busy, bus.Pe_Ack, bus.Done}), 64'b110);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", all_out(), 64'd0);
    step();
    chk("reset_hold", all_out(), 64'd0);
    #2 rst_n = 1'b1;
    bus.Qsd_in = '0;
    frame("after_reset", 8'd200, 8'd10, 8'd20, 8'd30, {16'd500, 16'd12},
          {16'd1, 16'd1}, {16'd1000, 16'd1000}, 0, 0, 1'b0, 1'b0);

    // Randomized frames.
    for (int i = 0; i < 6; i++) begin
      if (i == 5) rs = $urandom();
      else        rs = {16'($urandom_range(0, 1500)), 16'($urandom_range(0, 1500))};
      gs = {16'($urandom_range(0, 1100)), 16'($urandom_range(0, 1100))};
      bs = {16'($urandom_range(0, 2100)), 16'($urandom_range(0, 2100))};
      d_sum = int'($urandom_range(0, 5));
      frame($sformatf("rand%0d", i), 8'($urandom()), 8'($urandom()), 8'($urandom()),
            8'($urandom()), rs, gs, bs, d_sum, int'($urandom_range(0, 5)),
            (d_sum >= 2) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
